copy_cmd_queue: RTL and testbench

Command queue and sequencer that sits directly upstream of `copier`. It accepts copy descriptors (source, destination, size) through a valid/ready push port and buffers them in a FIFO. It issues them one at a time to `copier` by driving its `src_addr`/`dst_addr`/`copy_size`/`start` inputs, and retires each one on `finished`. This lets a host or testbench queue several copies back-to-back without polling the copier.

---
 rtl/copy_cmd_queue.sv | 106 ++++++++++
 tb/tb_copy_cmd_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/copy_cmd_queue.sv
// Descriptor FIFO and sequencer feeding the copier: buffers (src, dst, size) commands
// and issues them one at a time, retiring each on finished (or immediately if size is 0).
//
// state | meaning
// IDLE  | no copy in flight; pops the head descriptor whenever the queue is non-empty
// ISSUE | descriptor latched; start pulses for this one cycle
// WAIT  | copier running; retires on finished
module copy_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [AW-1:0]            cmd_src,
    input  logic [AW-1:0]            cmd_dst,
    input  logic [AW-1:0]            cmd_size,
    output logic [AW-1:0]            src_addr,
    output logic [AW-1:0]            dst_addr,
    output logic [AW-1:0]            copy_size,
    output logic                     start,
    input  logic                     finished,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic [7:0]               done_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   mem_src  [DEPTH];
    logic [AW-1:0]   mem_dst  [DEPTH];
    logic [AW-1:0]   mem_size [DEPTH];
    logic [PW-1:0]   head, tail;
    logic            push, pop, retire;

    // Ready depends on count alone, so a pop on a full queue never admits a push that edge.
    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign start     = (state == ISSUE);
    assign busy      = (count != '0) || (state != IDLE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (mem_size[head] != '0) state_nxt = ISSUE;
                    else                      retire    = 1'b1;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (finished) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_src[tail]  <= cmd_src;
            mem_dst[tail]  <= cmd_dst;
            mem_size[tail] <= cmd_size;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            done_count <= '0;
            src_addr   <= '0;
            dst_addr   <= '0;
            copy_size  <= '0;
        end else begin
            state <= state_nxt;
            if (push) tail <= tail + PW'(1);
            if (pop) begin
                head      <= head + PW'(1);
                src_addr  <= mem_src[head];
                dst_addr  <= mem_dst[head];
                copy_size <= mem_size[head];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (retire) done_count <= done_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_copy_cmd_queue.sv
// Self-checking bench for copy_cmd_queue: a queue-based reference model checked every
// cycle, plus hand-computed checkpoints for each directed scenario.
module tb_copy_cmd_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_src = '0, cmd_dst = '0, cmd_size = '0;
    logic          cmd_ready, start, busy;
    logic [AW-1:0] src_addr, dst_addr, copy_size;
    logic [2:0]    count;
    logic [7:0]    done_count;
    logic          fin_man = 1'b0, fin_auto = 1'b0, auto_fin = 1'b0;
    logic          finished;

    assign finished = fin_man | fin_auto;

    copy_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_size(cmd_size),
        .src_addr(src_addr), .dst_addr(dst_addr), .copy_size(copy_size),
        .start(start), .finished(finished),
        .count(count), .busy(busy), .done_count(done_count)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int starts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a descriptor queue plus the copier phase
    // (0 = nothing in flight, 1 = start cycle, 2 = awaiting finished).
    typedef struct {
        logic [7:0] s;
        logic [7:0] d;
        logic [7:0] z;
    } desc_t;

    desc_t      mq[$];
    desc_t      md;
    int         mphase = 0;
    bit         macc;
    logic [7:0] m_src = '0, m_dst = '0, m_size = '0, m_done = '0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mq.delete();
            mphase = 0;
            m_src  = '0;
            m_dst  = '0;
            m_size = '0;
            m_done = '0;
        end else begin
            macc = cmd_valid && (mq.size() != DEPTH);
            if (mphase == 0 && mq.size() != 0) begin
                md     = mq.pop_front();
                m_src  = md.s;
                m_dst  = md.d;
                m_size = md.z;
                if (md.z != 0) mphase = 1;
                else           m_done = m_done + 8'd1;
            end else if (mphase == 1) begin
                mphase = 2;
            end else if (mphase == 2 && finished) begin
                m_done = m_done + 8'd1;
                mphase = 0;
            end
            if (macc) begin
                md.s = cmd_src;
                md.d = cmd_dst;
                md.z = cmd_size;
                mq.push_back(md);
            end
        end
    end

    always @(negedge CLK) begin
        chk("count", 32'(count), 32'(mq.size()));
        chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() != DEPTH));
        chk("start", 32'(start), 32'(mphase == 1));
        chk("busy", 32'(busy), 32'((mq.size() != 0) || (mphase != 0)));
        chk("done_count", 32'(done_count), 32'(m_done));
        chk("src_addr", 32'(src_addr), 32'(m_src));
        chk("dst_addr", 32'(dst_addr), 32'(m_dst));
        chk("copy_size", 32'(copy_size), 32'(m_size));
        if (start) starts++;
    end

    // Auto copier: toggles finished every cycle while enabled; WAIT sees it within two edges.
    always begin
        @(posedge CLK);
        #1;
        fin_auto = auto_fin && !fin_auto;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] s, input logic [7:0] d, input logic [7:0] z);
        bit acc;
        int n;
        cmd_valid = 1'b1;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_size  = z;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            acc = cmd_ready;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL push_timeout: got not-accepted expected accepted (src=%0h)", s);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic pulse_fin();
        fin_man = 1'b1;
        tick();
        fin_man = 1'b0;
    endtask

    int s0;

    initial begin
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_done", 32'(done_count), 0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        tick();

        // Single command
        push(8'h00, 8'hF0, 8'h08);
        chk("t1_count", 32'(count), 1);
        chk("t1_start_e0", 32'(start), 0);
        tick();
        chk("t1_start", 32'(start), 1);
        chk("t1_src", 32'(src_addr), 32'h00);
        chk("t1_dst", 32'(dst_addr), 32'hF0);
        chk("t1_size", 32'(copy_size), 32'h08);
        tick();
        chk("t1_start_off", 32'(start), 0);
        chk("t1_dst_hold", 32'(dst_addr), 32'hF0);
        pulse_fin();
        chk("t1_done", 32'(done_count), 1);
        chk("t1_busy", 32'(busy), 0);

        // Fill to full with finished held low
        for (int k = 1; k <= 5; k++) push(8'(k), 8'(8'h40 + k), 8'(k));
        chk("t2_full_count", 32'(count), 4);
        chk("t2_full_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_src   = 8'h06;
        cmd_dst   = 8'h46;
        cmd_size  = 8'h06;
        pulse_fin();
        chk("t2_after_fin_ready", 32'(cmd_ready), 0);
        chk("t2_after_fin_count", 32'(count), 4);
        tick();
        chk("t2_pop_count", 32'(count), 3);
        chk("t2_pop_start", 32'(start), 1);
        chk("t2_pop_src", 32'(src_addr), 32'h02);
        tick();
        chk("t2_refill_count", 32'(count), 4);
        cmd_valid = 1'b0;
        auto_fin = 1'b1;
        wait_idle();
        chk("t2_done", 32'(done_count), 7);

        // Ordering across pointer wrap while retiring
        s0 = starts;
        for (int k = 1; k <= 6; k++) push(8'(16 * k), 8'(8'h70 + 16 * k), 8'h04);
        wait_idle();
        chk("t3_starts", 32'(starts - s0), 6);
        chk("t3_done", 32'(done_count), 13);
        chk("t3_last_src", 32'(src_addr), 32'h60);
        chk("t3_last_dst", 32'(dst_addr), 32'hD0);
        auto_fin = 1'b0;
        tick();
        tick();

        // Zero-size command followed by a normal one
        s0 = starts;
        push(8'h30, 8'hA0, 8'h00);
        push(8'h40, 8'hB0, 8'h04);
        chk("t4_zero_done", 32'(done_count), 14);
        chk("t4_zero_nostart", 32'(starts - s0), 0);
        tick();
        chk("t4_start", 32'(start), 1);
        chk("t4_size", 32'(copy_size), 32'h04);
        chk("t4_src", 32'(src_addr), 32'h40);
        tick();
        pulse_fin();
        chk("t4_done", 32'(done_count), 15);
        chk("t4_busy", 32'(busy), 0);

        // Spurious finished in IDLE and ISSUE
        pulse_fin();
        chk("t5_idle_done", 32'(done_count), 15);
        chk("t5_idle_busy", 32'(busy), 0);
        push(8'h50, 8'hC0, 8'h02);
        tick();
        chk("t5_issue_start", 32'(start), 1);
        pulse_fin();
        chk("t5_issue_done", 32'(done_count), 15);
        chk("t5_wait_busy", 32'(busy), 1);
        chk("t5_wait_start", 32'(start), 0);
        pulse_fin();
        chk("t5_done", 32'(done_count), 16);

        // Reset while in WAIT with two queued
        push(8'h01, 8'h02, 8'h03);
        push(8'h04, 8'h05, 8'h06);
        push(8'h07, 8'h08, 8'h09);
        chk("t6_pre_count", 32'(count), 2);
        chk("t6_pre_busy", 32'(busy), 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("t6_rst_start", 32'(start), 0);
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_done", 32'(done_count), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_ready", 32'(cmd_ready), 1);
        chk("t6_rst_src", 32'(src_addr), 0);
        @(posedge CLK);
        #3;
        nRST = 1'b1;
        s0 = starts;
        repeat (5) tick();
        chk("t6_no_start", 32'(starts - s0), 0);
        chk("t6_idle_busy", 32'(busy), 0);
        push(8'h11, 8'hD0, 8'h01);
        tick();
        chk("t6_new_start", 32'(start), 1);
        chk("t6_new_src", 32'(src_addr), 32'h11);
        tick();
        pulse_fin();
        chk("t6_new_done", 32'(done_count), 1);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion by 200000");
        $fatal(1, "watchdog");
    end

endmodule
